machine_csr_unit: RTL and testbench

- Machine-mode CSR file and trap controller for the single-cycle RV32I core.
- Holds the M-mode CSRs and serves CSR reads and writes from the decoder/ALU path.
- Detects exceptions and interrupts and selects the trap or return PC (mtvec/mepc) for the PC update logic.
- Purely M-mode; no privilege changes.

---
 rtl/machine_csr_unit.sv | 146 ++++++++++++++
 tb/tb_machine_csr_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/machine_csr_unit.sv
// Machine-mode CSR file and trap controller for the single-cycle RV32I core.
// Serves CSR reads/writes, prioritises interrupts over exceptions and
// selects mtvec/mepc as the next PC when a trap or MRET retires.
module machine_csr_unit #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        csr_instr,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_instr_src,
    output logic [31:0] csr_instr_dst,
    input  logic        mret_instr,
    input  logic        illegal_instr,
    input  logic        env_call,
    input  logic        break_point,
    input  logic        load_access,
    input  logic        timer_int,
    input  logic        soft_int,
    input  logic        ext_int,
    input  logic [31:0] pc,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        csr_pc_sel
);

    localparam logic [31:0] MIE_MASK = 32'h00000888;

    logic        status_mie;
    logic        status_mpie;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [63:0] mcycle_reg;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;
    logic [31:0] pending;
    logic        irq;
    logic        exc;
    logic        trap;
    logic        csr_we;
    logic [31:0] cause;

    assign mstatus_val = {19'd0, 2'b11, 3'd0, status_mpie, 3'd0, status_mie, 3'd0};
    assign mip_val     = {20'd0, ext_int, 3'd0, timer_int, 3'd0, soft_int, 3'd0};
    assign pending     = mie_reg & mip_val;
    assign irq         = status_mie && (pending != 32'd0);
    assign exc         = illegal_instr || break_point || env_call || load_access;
    assign trap        = !stall && !mret_instr && (irq || exc);
    assign csr_we      = csr_instr && !stall && !trap;
    assign csr_pc_sel  = !stall && (mret_instr || trap);
    assign mtvec       = mtvec_reg;
    assign mepc        = mepc_reg;

    // Trap cause: any enabled interrupt beats every exception.
    always_comb begin
        cause = 32'd0;
        if (irq) begin
            if (pending[11])      cause = 32'h8000000B;
            else if (pending[3])  cause = 32'h80000003;
            else                  cause = 32'h80000007;
        end else begin
            if (illegal_instr)    cause = 32'd2;
            else if (break_point) cause = 32'd3;
            else if (env_call)    cause = 32'd11;
            else                  cause = 32'd5;
        end
    end

    // CSR read mux; always returns the pre-write register contents.
    always_comb begin
        csr_instr_dst = 32'd0;
        case (csr_addr)
            12'h300: csr_instr_dst = mstatus_val;
            12'h301: csr_instr_dst = MISA_VALUE;
            12'h304: csr_instr_dst = mie_reg;
            12'h305: csr_instr_dst = mtvec_reg;
            12'h340: csr_instr_dst = mscratch_reg;
            12'h341: csr_instr_dst = mepc_reg;
            12'h342: csr_instr_dst = mcause_reg;
            12'h343: csr_instr_dst = mtval_reg;
            12'h344: csr_instr_dst = mip_val;
            12'hB00: csr_instr_dst = mcycle_reg[31:0];
            12'hB80: csr_instr_dst = mcycle_reg[63:32];
            12'hF14: csr_instr_dst = HART_ID;
            default: csr_instr_dst = 32'd0;
        endcase
    end

    // Cycle counter runs through stalls; a software write replaces the increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcycle_reg <= 64'd0;
        end else if (csr_we && csr_addr == 12'hB00) begin
            mcycle_reg <= {mcycle_reg[63:32], csr_instr_src};
        end else if (csr_we && csr_addr == 12'hB80) begin
            mcycle_reg <= {csr_instr_src, mcycle_reg[31:0]};
        end else begin
            mcycle_reg <= mcycle_reg + 64'd1;
        end
    end

    // Architectural CSR state: trap entry, MRET return, or software write.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_mie   <= 1'b0;
            status_mpie  <= 1'b0;
            mie_reg      <= 32'd0;
            mtvec_reg    <= 32'd0;
            mscratch_reg <= 32'd0;
            mepc_reg     <= 32'd0;
            mcause_reg   <= 32'd0;
            mtval_reg    <= 32'd0;
        end else if (trap) begin
            mepc_reg    <= {pc[31:2], 2'b00};
            mcause_reg  <= cause;
            mtval_reg   <= 32'd0;
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
        end else if (!stall && mret_instr) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: begin
                    status_mie  <= csr_instr_src[3];
                    status_mpie <= csr_instr_src[7];
                end
                12'h304: mie_reg      <= csr_instr_src & MIE_MASK;
                12'h305: mtvec_reg    <= {csr_instr_src[31:2], 2'b00};
                12'h340: mscratch_reg <= csr_instr_src;
                12'h341: mepc_reg     <= {csr_instr_src[31:2], 2'b00};
                12'h342: mcause_reg   <= csr_instr_src;
                12'h343: mtval_reg    <= csr_instr_src;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_machine_csr_unit.sv
// Directed bench for machine_csr_unit: reset values, CSR writes/masks,
// exception and interrupt trap entry, MRET, stall behaviour and mid-run reset.
module tb_machine_csr_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        csr_instr;
    logic [11:0] csr_addr;
    logic [31:0] csr_instr_src;
    logic [31:0] csr_instr_dst;
    logic        mret_instr;
    logic        illegal_instr;
    logic        env_call;
    logic        break_point;
    logic        load_access;
    logic        timer_int;
    logic        soft_int;
    logic        ext_int;
    logic [31:0] pc;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        csr_pc_sel;

    int n_checks = 0;
    int n_fail   = 0;

    machine_csr_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .csr_instr(csr_instr),
        .csr_addr(csr_addr), .csr_instr_src(csr_instr_src), .csr_instr_dst(csr_instr_dst),
        .mret_instr(mret_instr), .illegal_instr(illegal_instr), .env_call(env_call),
        .break_point(break_point), .load_access(load_access), .timer_int(timer_int),
        .soft_int(soft_int), .ext_int(ext_int), .pc(pc), .mtvec(mtvec), .mepc(mepc),
        .csr_pc_sel(csr_pc_sel)
    );

    always #10 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_instr = 1'b1; csr_addr = a; csr_instr_src = d;
        step();
        csr_instr = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 0; csr_instr = 0; csr_addr = 0; csr_instr_src = 0;
        mret_instr = 0; illegal_instr = 0; env_call = 0; break_point = 0; load_access = 0;
        timer_int = 0; soft_int = 0; ext_int = 0; pc = 0;
        step(); step();
        reset = 1'b0;
        rd(12'hB00);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL mcycle_0 got %h want %h", csr_instr_dst, 32'd0); end
        step();
        n_checks++; if (csr_instr_dst !== 32'd1) begin n_fail++; $display("FAIL mcycle_1 got %h want %h", csr_instr_dst, 32'd1); end
        step();
        n_checks++; if (csr_instr_dst !== 32'd2) begin n_fail++; $display("FAIL mcycle_2 got %h want %h", csr_instr_dst, 32'd2); end
        rd(12'h300);
        n_checks++; if (csr_instr_dst !== 32'h00001800) begin n_fail++; $display("FAIL mstatus_rst got %h want %h", csr_instr_dst, 32'h00001800); end
        rd(12'h301);
        n_checks++; if (csr_instr_dst !== 32'h40000100) begin n_fail++; $display("FAIL misa got %h want %h", csr_instr_dst, 32'h40000100); end
        rd(12'hF14);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL mhartid got %h want %h", csr_instr_dst, 32'd0); end
        n_checks++; if (mtvec !== 32'd0 || mepc !== 32'd0 || csr_pc_sel !== 1'b0) begin n_fail++; $display("FAIL rst_outputs got mtvec=%h mepc=%h sel=%b want 0 0 0", mtvec, mepc, csr_pc_sel); end
    endtask

    task automatic test_csr_write();
        wr(12'h305, 32'h80000103);
        n_checks++; if (mtvec !== 32'h80000100) begin n_fail++; $display("FAIL mtvec_mask got %h want %h", mtvec, 32'h80000100); end
        wr(12'h304, 32'hFFFFFFFF);
        rd(12'h304);
        n_checks++; if (csr_instr_dst !== 32'h00000888) begin n_fail++; $display("FAIL mie_mask got %h want %h", csr_instr_dst, 32'h00000888); end
        wr(12'h7C0, 32'h12345678);
        rd(12'h7C0);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL unmapped got %h want %h", csr_instr_dst, 32'd0); end
        wr(12'h340, 32'h12345678);
        rd(12'h340);
        n_checks++; if (csr_instr_dst !== 32'h12345678) begin n_fail++; $display("FAIL mscratch got %h want %h", csr_instr_dst, 32'h12345678); end
        wr(12'h341, 32'h00000123);
        n_checks++; if (mepc !== 32'h00000120) begin n_fail++; $display("FAIL mepc_mask got %h want %h", mepc, 32'h00000120); end
        wr(12'hB80, 32'hFFFFFFFF);
        wr(12'hB00, 32'hFFFFFFFF);
        rd(12'hB00);
        n_checks++; if (csr_instr_dst !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mcycle_wr_lo got %h want %h", csr_instr_dst, 32'hFFFFFFFF); end
        rd(12'hB80);
        n_checks++; if (csr_instr_dst !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mcycle_wr_hi got %h want %h", csr_instr_dst, 32'hFFFFFFFF); end
        step();
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL mcycle_wrap_hi got %h want %h", csr_instr_dst, 32'd0); end
        rd(12'hB00);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL mcycle_wrap_lo got %h want %h", csr_instr_dst, 32'd0); end
    endtask

    task automatic test_exception();
        wr(12'h300, 32'h00000008);
        rd(12'h300);
        n_checks++; if (csr_instr_dst !== 32'h00001808) begin n_fail++; $display("FAIL mstatus_wr got %h want %h", csr_instr_dst, 32'h00001808); end
        wr(12'h305, 32'h00000200);
        pc = 32'h100; env_call = 1;
        csr_instr = 1; csr_addr = 12'h340; csr_instr_src = 32'hDEADBEEF;
        #1;
        n_checks++; if (csr_pc_sel !== 1'b1) begin n_fail++; $display("FAIL ecall_sel got %b want %b", csr_pc_sel, 1'b1); end
        n_checks++; if (csr_instr_dst !== 32'h12345678) begin n_fail++; $display("FAIL prewrite_read got %h want %h", csr_instr_dst, 32'h12345678); end
        n_checks++; if (mtvec !== 32'h200) begin n_fail++; $display("FAIL ecall_mtvec got %h want %h", mtvec, 32'h200); end
        step();
        env_call = 0; csr_instr = 0;
        n_checks++; if (mepc !== 32'h100) begin n_fail++; $display("FAIL ecall_mepc got %h want %h", mepc, 32'h100); end
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'd11) begin n_fail++; $display("FAIL ecall_cause got %h want %h", csr_instr_dst, 32'd11); end
        rd(12'h300);
        n_checks++; if (csr_instr_dst !== 32'h00001880) begin n_fail++; $display("FAIL ecall_mstatus got %h want %h", csr_instr_dst, 32'h00001880); end
        rd(12'h343);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL ecall_mtval got %h want %h", csr_instr_dst, 32'd0); end
        rd(12'h340);
        n_checks++; if (csr_instr_dst !== 32'h12345678) begin n_fail++; $display("FAIL trap_suppress_wr got %h want %h", csr_instr_dst, 32'h12345678); end
        pc = 32'h107; illegal_instr = 1; break_point = 1; env_call = 1; load_access = 1;
        step();
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'd2) begin n_fail++; $display("FAIL prio_illegal got %h want %h", csr_instr_dst, 32'd2); end
        n_checks++; if (mepc !== 32'h104) begin n_fail++; $display("FAIL mepc_align got %h want %h", mepc, 32'h104); end
        illegal_instr = 0;
        step();
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'd3) begin n_fail++; $display("FAIL prio_break got %h want %h", csr_instr_dst, 32'd3); end
        break_point = 0; env_call = 0;
        step();
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'd5) begin n_fail++; $display("FAIL prio_load got %h want %h", csr_instr_dst, 32'd5); end
        load_access = 0;
    endtask

    task automatic test_interrupt();
        wr(12'h300, 32'h00001808);
        wr(12'h304, 32'h00000080);
        pc = 32'h40; timer_int = 1; illegal_instr = 1;
        rd(12'h344);
        n_checks++; if (csr_instr_dst !== 32'h80) begin n_fail++; $display("FAIL mip_live got %h want %h", csr_instr_dst, 32'h80); end
        n_checks++; if (csr_pc_sel !== 1'b1) begin n_fail++; $display("FAIL irq_sel got %b want %b", csr_pc_sel, 1'b1); end
        step();
        illegal_instr = 0;
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'h80000007) begin n_fail++; $display("FAIL irq_cause got %h want %h", csr_instr_dst, 32'h80000007); end
        n_checks++; if (mepc !== 32'h40) begin n_fail++; $display("FAIL irq_mepc got %h want %h", mepc, 32'h40); end
        rd(12'h300);
        n_checks++; if (csr_instr_dst !== 32'h00001880) begin n_fail++; $display("FAIL irq_mstatus got %h want %h", csr_instr_dst, 32'h00001880); end
        n_checks++; if (csr_pc_sel !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want %b", csr_pc_sel, 1'b0); end
        mret_instr = 1;
        #1;
        n_checks++; if (csr_pc_sel !== 1'b1 || mepc !== 32'h40) begin n_fail++; $display("FAIL mret_sel got sel=%b mepc=%h want 1 %h", csr_pc_sel, mepc, 32'h40); end
        step();
        mret_instr = 0; timer_int = 0;
        rd(12'h300);
        n_checks++; if (csr_instr_dst !== 32'h00001888) begin n_fail++; $display("FAIL mret_mstatus got %h want %h", csr_instr_dst, 32'h00001888); end
    endtask

    task automatic test_stall();
        wr(12'h304, 32'h00000888);
        wr(12'hB00, 32'd100);
        stall = 1; ext_int = 1; soft_int = 1; timer_int = 1; pc = 32'h80;
        csr_instr = 1; csr_addr = 12'h340; csr_instr_src = 32'hCAFEF00D;
        #1;
        n_checks++; if (csr_pc_sel !== 1'b0) begin n_fail++; $display("FAIL stall_sel got %b want %b", csr_pc_sel, 1'b0); end
        step(); step();
        rd(12'h340);
        n_checks++; if (csr_instr_dst !== 32'h12345678) begin n_fail++; $display("FAIL stall_nowrite got %h want %h", csr_instr_dst, 32'h12345678); end
        rd(12'hB00);
        n_checks++; if (csr_instr_dst !== 32'd102) begin n_fail++; $display("FAIL stall_mcycle got %h want %h", csr_instr_dst, 32'd102); end
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'h80000007) begin n_fail++; $display("FAIL stall_notrap got %h want %h", csr_instr_dst, 32'h80000007); end
        csr_instr = 0; stall = 0;
        #1;
        n_checks++; if (csr_pc_sel !== 1'b1) begin n_fail++; $display("FAIL unstall_sel got %b want %b", csr_pc_sel, 1'b1); end
        step();
        ext_int = 0;
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'h8000000B) begin n_fail++; $display("FAIL ext_cause got %h want %h", csr_instr_dst, 32'h8000000B); end
        n_checks++; if (mepc !== 32'h80) begin n_fail++; $display("FAIL ext_mepc got %h want %h", mepc, 32'h80); end
        mret_instr = 1; pc = 32'h84;
        step();
        mret_instr = 0;
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'h8000000B) begin n_fail++; $display("FAIL mret_nocause got %h want %h", csr_instr_dst, 32'h8000000B); end
        n_checks++; if (csr_pc_sel !== 1'b1) begin n_fail++; $display("FAIL soft_pending got %b want %b", csr_pc_sel, 1'b1); end
        step();
        soft_int = 0; timer_int = 0;
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'h80000003) begin n_fail++; $display("FAIL soft_over_timer got %h want %h", csr_instr_dst, 32'h80000003); end
    endtask

    task automatic test_reset_mid();
        env_call = 1; pc = 32'h300;
        csr_instr = 1; csr_addr = 12'h305; csr_instr_src = 32'h00000400;
        reset = 1;
        step();
        reset = 0; env_call = 0; csr_instr = 0;
        n_checks++; if (mepc !== 32'd0 || mtvec !== 32'd0) begin n_fail++; $display("FAIL rst_mid_pc got mepc=%h mtvec=%h want 0 0", mepc, mtvec); end
        rd(12'h342);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL rst_mid_cause got %h want %h", csr_instr_dst, 32'd0); end
        rd(12'h300);
        n_checks++; if (csr_instr_dst !== 32'h00001800) begin n_fail++; $display("FAIL rst_mid_mstatus got %h want %h", csr_instr_dst, 32'h00001800); end
        rd(12'hB00);
        n_checks++; if (csr_instr_dst !== 32'd0) begin n_fail++; $display("FAIL rst_mid_mcycle got %h want %h", csr_instr_dst, 32'd0); end
    endtask

    initial begin
        test_reset();
        test_csr_write();
        test_exception();
        test_interrupt();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
